// File: rtl/mfp_ahb_loader_arbiter_if.sv
// mfp_ahb_loader_arbiter_if: two AHB-Lite master ports, the merged slave-side bus
// and the loader handshake/hold signals.
interface mfp_ahb_loader_arbiter_if;
  logic [31:0] cpu_HADDR, ldr_HADDR, m_HADDR;
  logic [2:0]  cpu_HBURST, ldr_HBURST, m_HBURST;
  logic        cpu_HMASTLOCK, ldr_HMASTLOCK, m_HMASTLOCK;
  logic [3:0]  cpu_HPROT, ldr_HPROT, m_HPROT;
  logic [2:0]  cpu_HSIZE, ldr_HSIZE, m_HSIZE;
  logic [1:0]  cpu_HTRANS, ldr_HTRANS, m_HTRANS;
  logic [31:0] cpu_HWDATA, ldr_HWDATA, m_HWDATA;
  logic        cpu_HWRITE, ldr_HWRITE, m_HWRITE;
  logic        ldr_req, HREADY, ldr_grant, ldr_ready, cpu_hold;
  modport master (
    output cpu_HADDR, cpu_HBURST, cpu_HMASTLOCK, cpu_HPROT, cpu_HSIZE, cpu_HTRANS, cpu_HWDATA, cpu_HWRITE,
    output ldr_HADDR, ldr_HBURST, ldr_HMASTLOCK, ldr_HPROT, ldr_HSIZE, ldr_HTRANS, ldr_HWDATA, ldr_HWRITE,
    output ldr_req, HREADY,
    input  m_HADDR, m_HBURST, m_HMASTLOCK, m_HPROT, m_HSIZE, m_HTRANS, m_HWDATA, m_HWRITE,
    input  ldr_grant, ldr_ready, cpu_hold
  );
  modport slave (
    input  cpu_HADDR, cpu_HBURST, cpu_HMASTLOCK, cpu_HPROT, cpu_HSIZE, cpu_HTRANS, cpu_HWDATA, cpu_HWRITE,
    input  ldr_HADDR, ldr_HBURST, ldr_HMASTLOCK, ldr_HPROT, ldr_HSIZE, ldr_HTRANS, ldr_HWDATA, ldr_HWRITE,
    input  ldr_req, HREADY,
    output m_HADDR, m_HBURST, m_HMASTLOCK, m_HPROT, m_HSIZE, m_HTRANS, m_HWDATA, m_HWRITE,
    output ldr_grant, ldr_ready, cpu_hold
  );
endinterface

// File: rtl/mfp_ahb_loader_arbiter.sv
// mfp_ahb_loader_arbiter: hands the AHB bus between core and serial loader on clean
// transfer boundaries; write data follows the data-phase owner, core held in reset while loading.
module mfp_ahb_loader_arbiter #(
  parameter int RETURN_GAP = 4
) (
  input logic HCLK,
  input logic HRESETn,
  mfp_ahb_loader_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_CPU, S_DRAIN, S_LOADER, S_RETURN} state_t;
  typedef enum logic [1:0] {O_CPU, O_LDR, O_NONE} owner_t;
  state_t r_state, w_next;
  owner_t r_dp_owner, w_ap_owner;
  logic [3:0] r_gap_cnt, w_gap_next;
  logic r_cpu_hold, w_cpu, w_ldr, w_gap_done;
  assign w_cpu = r_state == S_CPU;
  assign w_ldr = r_state == S_LOADER;
  assign w_gap_done = r_gap_cnt == 4'(RETURN_GAP - 1);
  assign w_ap_owner = w_cpu ? O_CPU : w_ldr ? O_LDR : O_NONE;
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= S_CPU;
      r_dp_owner <= O_CPU;
      r_gap_cnt  <= '0;
      r_cpu_hold <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_gap_cnt  <= w_gap_next;
      r_cpu_hold <= w_next != S_CPU;
      if (bus.HREADY) r_dp_owner <= w_ap_owner;
    end
  end
  always_comb begin
    w_next     = r_state;
    w_gap_next = r_gap_cnt;
    case (r_state)
      // a locked CPU sequence must finish before the loader can be let in
      S_CPU:    if (bus.ldr_req && !(bus.cpu_HMASTLOCK && bus.cpu_HTRANS != 2'b00)) w_next = S_DRAIN;
      S_DRAIN:  if (bus.HREADY) w_next = S_LOADER;
      S_LOADER: if (!bus.ldr_req && bus.HREADY) w_next = S_RETURN;
      S_RETURN: if (bus.HREADY) begin
        w_next     = w_gap_done ? S_CPU : S_RETURN;
        w_gap_next = w_gap_done ? 4'd0 : r_gap_cnt + 4'd1;
      end
      default:  w_next = S_CPU;
    endcase
  end
  assign bus.m_HADDR     = w_cpu ? bus.cpu_HADDR     : w_ldr ? bus.ldr_HADDR     : '0;
  assign bus.m_HBURST    = w_cpu ? bus.cpu_HBURST    : w_ldr ? bus.ldr_HBURST    : '0;
  assign bus.m_HMASTLOCK = w_cpu ? bus.cpu_HMASTLOCK : w_ldr ? bus.ldr_HMASTLOCK : 1'b0;
  assign bus.m_HPROT     = w_cpu ? bus.cpu_HPROT     : w_ldr ? bus.ldr_HPROT     : '0;
  assign bus.m_HSIZE     = w_cpu ? bus.cpu_HSIZE     : w_ldr ? bus.ldr_HSIZE     : '0;
  assign bus.m_HTRANS    = w_cpu ? bus.cpu_HTRANS    : w_ldr ? bus.ldr_HTRANS    : 2'b00;
  assign bus.m_HWRITE    = w_cpu ? bus.cpu_HWRITE    : w_ldr ? bus.ldr_HWRITE    : 1'b0;
  assign bus.m_HWDATA    = r_dp_owner == O_LDR ? bus.ldr_HWDATA : r_dp_owner == O_NONE ? 32'h0 : bus.cpu_HWDATA;
  assign bus.ldr_grant   = w_ldr;
  assign bus.ldr_ready   = w_ldr & bus.HREADY;
  assign bus.cpu_hold    = r_cpu_hold;
endmodule
